// File: rtl/regbank_wr_arbiter_pkg.sv
// Shared types for the two-requester register-bank write arbiter.
//   state_e  : arbiter FSM states
//   id_t     : requester identifier (0 or 1)
//   LAST_RST : reset value of the last-winner pointer, so requester 0
//              wins the first contention after reset
package regbank_wr_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_e;

    typedef logic id_t;

    localparam id_t LAST_RST = 1'b1;

endpackage

// File: rtl/regbank_wr_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker.
//   req[1:0]  : request vector, bit i = requester i
//   last      : requester that won the previous grant
//   winner_id : selected requester (only meaningful when any=1)
//   any       : at least one request is pending
module rr_arb2
    import regbank_wr_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  id_t        last,
    output id_t        winner_id,
    output logic       any
);

    // Contention favours the requester that did not win last time.
    always_comb begin
        any       = |req;
        winner_id = 1'b0;
        if (req == 2'b11) begin
            winner_id = ~last;
        end else if (req[1]) begin
            winner_id = 1'b1;
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter in front of a shared DEPTH x WIDTH register bank.
// Every write takes a grant cycle (IDLE -> COMMIT) and a commit cycle
// (COMMIT -> IDLE); a registered read port runs independently.
//   CLK, RN               : clock, asynchronous active-low reset
//   REQ0/ADDR0/WDATA0     : requester 0 write request, address, data
//   GNT0                  : one-cycle grant pulse to requester 0
//   REQ1/ADDR1/WDATA1     : requester 1 write request, address, data
//   GNT1                  : one-cycle grant pulse to requester 1
//   RADDR / RDATA         : read address / registered read data (0 if out of range)
//   BUSY                  : high while the FSM is in COMMIT
//   WR_DROP               : one-cycle pulse after a commit to an address >= DEPTH
module regbank_wr_arbiter
    import regbank_wr_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ0,
    input  logic [AW-1:0]    ADDR0,
    input  logic [WIDTH-1:0] WDATA0,
    output logic             GNT0,
    input  logic             REQ1,
    input  logic [AW-1:0]    ADDR1,
    input  logic [WIDTH-1:0] WDATA1,
    output logic             GNT1,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA,
    output logic             BUSY,
    output logic             WR_DROP
);

    state_e           state_q, state_d;
    id_t              last_q, last_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Staging for the write in flight; the grant flops double as its id.
    logic [AW-1:0]    stg_addr_q;
    logic [WIDTH-1:0] stg_data_q;

    logic [WIDTH-1:0] bank [DEPTH];

    id_t  win_c;
    logic any_c;
    logic cap_c;
    logic wr_en_c;
    logic stg_in_range_c;
    logic rd_in_range_c;

    rr_arb2 u_arb (
        .req       ({REQ1, REQ0}),
        .last      (last_q),
        .winner_id (win_c),
        .any       (any_c)
    );

    assign stg_in_range_c = 32'(stg_addr_q) < DEPTH;
    assign rd_in_range_c  = 32'(RADDR) < DEPTH;
    // state_q is cleared asynchronously, so a reset during COMMIT blocks the write.
    assign wr_en_c        = (state_q == COMMIT) && stg_in_range_c;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        drop_d  = 1'b0;
        cap_c   = 1'b0;
        rdata_d = rd_in_range_c ? bank[RADDR] : '0;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    cap_c   = 1'b1;
                    last_d  = win_c;
                    gnt0_d  = (win_c == 1'b0);
                    gnt1_d  = (win_c == 1'b1);
                    busy_d  = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                drop_d  = ~stg_in_range_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
        end
    end

    // Staging capture on grant; no reset needed.
    always_ff @(posedge CLK) begin
        if (cap_c) begin
            stg_addr_q <= (win_c == 1'b1) ? ADDR1 : ADDR0;
            stg_data_q <= (win_c == 1'b1) ? WDATA1 : WDATA0;
        end
    end

    // Bank storage: plain non-resettable flops.
    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            bank[stg_addr_q] <= stg_data_q;
        end
    end

    assign GNT0    = gnt0_q;
    assign GNT1    = gnt1_q;
    assign BUSY    = busy_q;
    assign WR_DROP = drop_q;
    assign RDATA   = rdata_q;

endmodule
